// File: rtl/mood_pkg.sv
// Shared constants for the mood-light button front end.
package mood_pkg;

    localparam int unsigned NUM_BTN      = 4;
    localparam int unsigned DEBOUNCE_CYC = 250000;

    localparam int unsigned BTN_MODE  = 0;
    localparam int unsigned BTN_UP    = 1;
    localparam int unsigned BTN_DOWN  = 2;
    localparam int unsigned BTN_COLOR = 3;

    typedef enum logic {
        ARB_IDLE,
        ARB_HOLD
    } arb_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus counter debounce for one active-low button.
// press_evt_o pulses combinationally on the edge at which a press is accepted.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYC = mood_pkg::DEBOUNCE_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n_i,
    output logic press_evt_o
);

    localparam int unsigned     CNT_W   = $clog2(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

    logic [1:0]       sync_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            sync_q   <= {sync_q[0], btn_n_i};
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        stable_d    = stable_q;
        cnt_d       = cnt_q;
        press_evt_o = 1'b0;
        if (sync_q[1] == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            stable_d    = sync_q[1];
            cnt_d       = '0;
            // only the 1->0 transition of the accepted level is a press
            press_evt_o = ~sync_q[1];
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/btn_cmd_arbiter.sv
// Debounced button presses become pending requests, serialized by a
// round-robin arbiter into a valid/ready command stream.
module btn_cmd_arbiter #(
    parameter int unsigned NUM_BTN      = mood_pkg::NUM_BTN,
    parameter int unsigned DEBOUNCE_CYC = mood_pkg::DEBOUNCE_CYC,
    parameter int unsigned ID_W         = $clog2(NUM_BTN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_n,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    output logic [ID_W-1:0]    cmd_id,
    output logic [NUM_BTN-1:0] pend,
    output logic               drop
);

    mood_pkg::arb_state_e state_q, state_d;

    logic [NUM_BTN-1:0] press_evt;
    logic [NUM_BTN-1:0] pend_q, pend_d;
    logic [NUM_BTN-1:0] load_mask;
    logic [ID_W-1:0]    cmd_id_q, cmd_id_d;
    logic [ID_W-1:0]    last_q, last_d;
    logic [ID_W-1:0]    winner;
    logic               any_pend;
    logic               found;
    logic               load;
    logic               drop_q, drop_d;
    int unsigned        idx;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_deb (
            .clk        (clk),
            .rst        (rst),
            .btn_n_i    (btn_n[g]),
            .press_evt_o(press_evt[g])
        );
    end

    // Round-robin search starting one past the last granted button.
    always_comb begin
        any_pend = |pend_q;
        winner   = last_q;
        found    = 1'b0;
        idx      = 0;
        for (int unsigned k = 1; k <= NUM_BTN; k++) begin
            idx = 32'(last_q) + k;
            if (idx >= NUM_BTN) begin
                idx = idx - NUM_BTN;
            end
            if (!found && pend_q[idx[ID_W-1:0]]) begin
                found  = 1'b1;
                winner = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            mood_pkg::ARB_IDLE: begin
                if (any_pend) begin
                    load    = 1'b1;
                    state_d = mood_pkg::ARB_HOLD;
                end
            end
            mood_pkg::ARB_HOLD: begin
                if (cmd_ready) begin
                    if (any_pend) begin
                        load = 1'b1;
                    end else begin
                        state_d = mood_pkg::ARB_IDLE;
                    end
                end
            end
            default: state_d = mood_pkg::ARB_IDLE;
        endcase
    end

    always_comb begin
        load_mask = '0;
        if (load) begin
            load_mask = NUM_BTN'(1) << winner;
        end
        // a press on the same edge as its own load re-arms the flag
        pend_d   = (pend_q & ~load_mask) | press_evt;
        drop_d   = |(press_evt & pend_q & ~load_mask);
        cmd_id_d = load ? winner : cmd_id_q;
        last_d   = load ? winner : last_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= mood_pkg::ARB_IDLE;
            pend_q   <= '0;
            cmd_id_q <= '0;
            last_q   <= ID_W'(NUM_BTN - 1);
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            cmd_id_q <= cmd_id_d;
            last_q   <= last_d;
            drop_q   <= drop_d;
        end
    end

    assign cmd_valid = (state_q == mood_pkg::ARB_HOLD);
    assign cmd_id    = cmd_id_q;
    assign pend      = pend_q;
    assign drop      = drop_q;

endmodule
